mult_booth_seq: RTL



---
 rtl/cpu_pkg.sv | 12 +
 rtl/booth_step.sv | 30 +++
 rtl/mult_booth_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: multiplier FSM encodings and default width.
package cpu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then an
// arithmetic right shift of {A,Q,q_1}.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q1_in,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q1_out
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_in;
        case ({q_in[0], q1_in})
            2'b01:   sum = acc_in + m;
            2'b10:   sum = acc_in - m;
            default: sum = acc_in;
        endcase
        // Sign bit of A is replicated; A's LSB falls into Q's MSB.
        acc_out = {sum[WIDTH], sum[WIDTH:1]};
        q_out   = {sum[0], q_in[WIDTH-1:1]};
        q1_out  = q_in[0];
    end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth signed multiplier; one step per clock, product
// presented on hi/lo with a one-cycle done pulse.
module mult_booth_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_e       state, state_nx;
    logic [WIDTH:0]   m_r, acc_r, acc_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic             q1_r, q1_nx;
    logic [CW-1:0]    cnt;
    logic             last_step;

    assign last_step = (cnt == CW'(1));

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in (acc_r),
        .q_in   (q_r),
        .q1_in  (q1_r),
        .m      (m_r),
        .acc_out(acc_nx),
        .q_out  (q_nx),
        .q1_out (q1_nx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            MUL_IDLE: if (start) state_nx = MUL_RUN;
            MUL_RUN:  if (last_step) state_nx = MUL_DONE;
            MUL_DONE: state_nx = MUL_IDLE;
            default:  state_nx = MUL_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they come straight off flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MUL_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == MUL_RUN);
            done  <= (state_nx == MUL_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_r   <= '0;
            acc_r <= '0;
            q_r   <= '0;
            q1_r  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (state == MUL_IDLE && start) begin
                m_r   <= {a[WIDTH-1], a};
                acc_r <= '0;
                q_r   <= b;
                q1_r  <= 1'b0;
                cnt   <= CW'(WIDTH);
            end else if (state == MUL_RUN) begin
                acc_r <= acc_nx;
                q_r   <= q_nx;
                q1_r  <= q1_nx;
                cnt   <= cnt - CW'(1);
                if (last_step) begin
                    hi <= acc_nx[WIDTH-1:0];
                    lo <= q_nx;
                end
            end
        end
    end

endmodule
